bf_loop_control: RTL

//  Executes the '[' / ']' instructions of the brainfuck computer. Sits between instruction fetch/decode
//  and the 32-entry loop stack.

---
 rtl/bf_loop_control_pkg.sv | 25 ++
 rtl/bf_loop_control.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bf_loop_control_pkg.sv
// Shared definitions for the brainfuck loop controller: opcodes, FSM states, default sizes.
package bf_loop_control_pkg;

  localparam int BF_ADDR_W  = 10;
  localparam int BF_DEPTH   = 32;
  localparam int BF_DEPTH_W = 6;

  localparam logic [2:0] OP_INC_PTR  = 3'd0;
  localparam logic [2:0] OP_DEC_PTR  = 3'd1;
  localparam logic [2:0] OP_INC      = 3'd2;
  localparam logic [2:0] OP_DEC      = 3'd3;
  localparam logic [2:0] OP_OUT      = 3'd4;
  localparam logic [2:0] OP_IN       = 3'd5;
  localparam logic [2:0] OP_LOOP_BEG = 3'd6;
  localparam logic [2:0] OP_LOOP_END = 3'd7;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SKIP     = 3'd1,
    ST_POP_WAIT = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

endpackage

// File: rtl/bf_loop_control.sv
// Executes '[' / ']': drives the loop stack, redirects fetch on a taken back-branch,
// and suppresses execution while skipping a loop entered with a zero cell.
module bf_loop_control
  import bf_loop_control_pkg::*;
#(
  parameter int ADDR_W  = BF_ADDR_W,
  parameter int DEPTH   = BF_DEPTH,
  parameter int DEPTH_W = BF_DEPTH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              cell_zero,
  input  logic [ADDR_W-1:0] stack_rdata,
  output logic              stack_push,
  output logic              stack_pop,
  output logic [ADDR_W-1:0] stack_wdata,
  output logic              stack_flush,
  output logic              stall,
  output logic              exec_suppress,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              err_overflow,
  output logic              err_underflow
);

  state_e              state, state_nxt;
  logic [DEPTH_W-1:0]  loop_depth;
  logic [ADDR_W-1:0]   skip_cnt;

  logic accept, op_beg, op_end, full, empty;
  logic do_push, do_pop, set_ovf, set_unf, skip_enter, skip_up, skip_down;

  assign accept = instr_valid & ~stall;
  assign op_beg = accept & (instr_op == OP_LOOP_BEG);
  assign op_end = accept & (instr_op == OP_LOOP_END);
  assign full   = (loop_depth == DEPTH_W'(DEPTH));
  assign empty  = (loop_depth == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (op_beg) begin
          if (cell_zero)  state_nxt = ST_SKIP;
          else if (full)  state_nxt = ST_ERROR;
        end else if (op_end) begin
          if (empty)           state_nxt = ST_ERROR;
          else if (!cell_zero) state_nxt = ST_POP_WAIT;
        end
      end
      ST_SKIP:     if (op_end && skip_cnt == ADDR_W'(1)) state_nxt = ST_RUN;
      ST_POP_WAIT: state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_RUN;
      ST_ERROR:    state_nxt = ST_ERROR;
      default:     state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    stall         = (state == ST_POP_WAIT) || (state == ST_REDIRECT) || (state == ST_ERROR);
    exec_suppress = (state == ST_SKIP) || (state == ST_ERROR);
    do_push    = 1'b0;
    do_pop     = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    skip_enter = 1'b0;
    skip_up    = 1'b0;
    skip_down  = 1'b0;
    case (state)
      ST_RUN: begin
        if (op_beg) begin
          if (cell_zero) skip_enter = 1'b1;
          else if (full) set_ovf    = 1'b1;
          else           do_push    = 1'b1;
        end else if (op_end) begin
          if (empty) set_unf = 1'b1;
          else       do_pop  = 1'b1;
        end
      end
      ST_SKIP: begin
        skip_up   = op_beg;
        skip_down = op_end;
      end
      default: ;
    endcase
  end

  // Pulses and redirect are registered; the popped address arrives during POP_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      stack_push    <= 1'b0;
      stack_pop     <= 1'b0;
      stack_wdata   <= '0;
      stack_flush   <= 1'b1;
      pc_load       <= 1'b0;
      pc_target     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      loop_depth    <= '0;
      skip_cnt      <= '0;
    end else begin
      stack_flush <= 1'b0;
      stack_push  <= do_push;
      stack_pop   <= do_pop;
      if (do_push) stack_wdata <= instr_addr;
      pc_load <= (state == ST_POP_WAIT);
      if (state == ST_POP_WAIT) pc_target <= stack_rdata;
      if (set_ovf) err_overflow  <= 1'b1;
      if (set_unf) err_underflow <= 1'b1;
      if (do_push)     loop_depth <= loop_depth + DEPTH_W'(1);
      else if (do_pop) loop_depth <= loop_depth - DEPTH_W'(1);
      if (skip_enter)     skip_cnt <= ADDR_W'(1);
      else if (skip_up)   skip_cnt <= skip_cnt + ADDR_W'(1);
      else if (skip_down) skip_cnt <= skip_cnt - ADDR_W'(1);
    end
  end

endmodule
